// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with frame-level debounce.
//
// Drives one column low at a time for SCAN_CYCLES clocks and samples the
// synchronized rows on the last dwell cycle. A full frame covers all four
// columns. At the end of each frame the frame result (single key, or none)
// feeds a debounce counter. Once the same result has been seen
// DEBOUNCE_SCANS frames in a row, the outputs update on the following clock.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   keyPad_row     [3:0] row lines, active-low
//   keyPad_column  [3:0] column drive, one-hot active-low
//   digit          [3:0] hex code of the debounced key
//   valid          level, high while a debounced key is held
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyPad_row,
  output logic [3:0] keyPad_column,
  output logic [3:0] digit,
  output logic       valid
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] LAST_DWELL = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_SCANS);

  function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
      default:  k = (c == 2'd0) ? 4'h0 : (c == 2'd1) ? 4'hF : (c == 2'd2) ? 4'hE : 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  // acc_hits: 0 = nothing seen this frame, 1 = exactly one key, 2 = more than one
  logic [1:0]    acc_hits_q, acc_hits_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic          cand_key_q, cand_key_d;
  logic [3:0]    cand_code_q, cand_code_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          upd_q, upd_d;
  // lock: a rollover was rejected; no key is accepted until a stable none
  logic          lock_q, lock_d;
  logic [3:0]    digit_q, digit_d;
  logic          valid_q, valid_d;

  logic [3:0] row_low;
  logic [2:0] n_low;
  logic [1:0] low_idx;
  logic [1:0] hits_now;
  logic [3:0] code_now;
  logic       last_dwell;
  logic       res_key;
  logic       same_res;

  always_comb begin
    row_low = ~row_s2_q;
    n_low   = '0;
    low_idx = '0;
    for (int i = 0; i < 4; i++) begin
      n_low = n_low + {2'b00, row_low[i]};
      if (row_low[i]) low_idx = 2'(i);
    end

    // Merge this column's sample into the frame accumulator (saturating at 2).
    if (n_low == 3'd0)                           hits_now = acc_hits_q;
    else if (acc_hits_q == 2'd0 && n_low == 3'd1) hits_now = 2'd1;
    else                                          hits_now = 2'd2;
    code_now = (acc_hits_q == 2'd0 && n_low == 3'd1) ? code_of(low_idx, col_q) : acc_code_q;

    last_dwell = (dwell_q == LAST_DWELL);
    res_key    = (hits_now == 2'd1);
    same_res   = (res_key == cand_key_q) && (!res_key || code_now == cand_code_q);

    row_s1_d    = keyPad_row;
    row_s2_d    = row_s1_q;
    dwell_d     = last_dwell ? '0 : dwell_q + DW'(1);
    col_d       = last_dwell ? col_q + 2'd1 : col_q;
    acc_hits_d  = acc_hits_q;
    acc_code_d  = acc_code_q;
    cand_key_d  = cand_key_q;
    cand_code_d = cand_code_q;
    deb_cnt_d   = deb_cnt_q;
    upd_d       = 1'b0;
    lock_d      = lock_q;
    digit_d     = digit_q;
    valid_d     = valid_q;

    if (last_dwell) begin
      if (col_q == 2'd3) begin
        acc_hits_d = 2'd0;
        acc_code_d = 4'h0;
        upd_d      = 1'b1;
        if (same_res) begin
          if (deb_cnt_q != DEB_MAX) deb_cnt_d = deb_cnt_q + CW'(1);
        end else begin
          cand_key_d  = res_key;
          cand_code_d = res_key ? code_now : 4'h0;
          deb_cnt_d   = CW'(1);
        end
      end else begin
        acc_hits_d = hits_now;
        acc_code_d = code_now;
      end
    end

    // Output decision runs one clock after the frame end, on the updated candidate.
    if (upd_q && deb_cnt_q == DEB_MAX) begin
      if (!cand_key_q) begin
        valid_d = 1'b0;
        lock_d  = 1'b0;
      end else if (!valid_q) begin
        if (!lock_q) begin
          digit_d = cand_code_q;
          valid_d = 1'b1;
        end
      end else if (cand_code_q != digit_q) begin
        valid_d = 1'b0;
        lock_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q    <= 4'b1111;
      row_s2_q    <= 4'b1111;
      dwell_q     <= '0;
      col_q       <= 2'd0;
      acc_hits_q  <= 2'd0;
      acc_code_q  <= 4'h0;
      cand_key_q  <= 1'b0;
      cand_code_q <= 4'h0;
      deb_cnt_q   <= '0;
      upd_q       <= 1'b0;
      lock_q      <= 1'b0;
      digit_q     <= 4'h0;
      valid_q     <= 1'b0;
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      acc_hits_q  <= acc_hits_d;
      acc_code_q  <= acc_code_d;
      cand_key_q  <= cand_key_d;
      cand_code_q <= cand_code_d;
      deb_cnt_q   <= deb_cnt_d;
      upd_q       <= upd_d;
      lock_q      <= lock_d;
      digit_q     <= digit_d;
      valid_q     <= valid_d;
    end
  end

  assign keyPad_column = ~(4'b0001 << col_q);
  assign digit         = digit_q;
  assign valid         = valid_q;

endmodule
